// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring radix-2 divider.
// Optional divide-by-zero flag is enabled by defining DIVIDER_DBZ_EN.
package divider_pkg;

    localparam int DIVIDER_N = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
// div_by_zero exists only when DIVIDER_DBZ_EN is defined.
interface divider_if #(
    parameter int N = divider_pkg::DIVIDER_N
);
    logic         start;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
`ifdef DIVIDER_DBZ_EN
    logic         div_by_zero;

    modport master (output start, in1, in2,
                    input  ready, quotient, remainder, div_by_zero);
    modport slave  (input  start, in1, in2,
                    output ready, quotient, remainder, div_by_zero);
`else
    modport master (output start, in1, in2,
                    input  ready, quotient, remainder);
    modport slave  (input  start, in1, in2,
                    output ready, quotient, remainder);
`endif
endinterface

// File: rtl/divider_step.sv
// One combinational restoring division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it is non-negative.
module divider_step #(
    parameter int N = divider_pkg::DIVIDER_N
) (
    input  logic [N:0]   rem_in,
    input  logic         dividend_bit,
    input  logic [N-1:0] divisor,
    output logic [N:0]   rem_out,
    output logic         q_bit
);
    logic [N+1:0] shifted;
    logic [N+1:0] diff;

    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {2'b00, divisor};

    // A zero divisor always "fits"; this keeps the top bit of a growing
    // partial remainder from flipping the sign test.
    assign q_bit   = ~diff[N+1] | (divisor == '0);
    assign rem_out = q_bit ? diff[N:0] : shifted[N:0];

endmodule

// File: rtl/divider.sv
// Multi-cycle unsigned divider: one restoring step per clock, N clocks per result.
// Define DIVIDER_DBZ_EN to add the div_by_zero flag and a 1-cycle zero-divisor path.
module divider
    import divider_pkg::*;
#(
    parameter int N = DIVIDER_N
) (
    input logic      clock,
    input logic      reset,
    divider_if.slave bus
);
    localparam int            CW        = $clog2(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] count_reg;
    logic [N-1:0]  dividend_reg;
    logic [N-1:0]  divisor_reg;
    logic [N-1:0]  quot_reg;
    logic [N:0]    rem_reg;
    logic [N:0]    step_rem_in;
    logic [N:0]    step_rem_out;
    logic          step_q_bit;
    logic          last_step;
`ifdef DIVIDER_DBZ_EN
    logic          dbz_reg;
`endif

    assign last_step = (count_reg == LAST_STEP);

    // The first step starts from a zero partial remainder, so the visible
    // result registers are left untouched until BUSY actually begins.
    assign step_rem_in = (count_reg == '0) ? '0 : rem_reg;

    divider_step #(.N(N)) u_step (
        .rem_in       (step_rem_in),
        .dividend_bit (dividend_reg[N-1]),
        .divisor      (divisor_reg),
        .rem_out      (step_rem_out),
        .q_bit        (step_q_bit)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
`ifdef DIVIDER_DBZ_EN
                if (dbz_reg || last_step) begin
                    state_next = DONE;
                end
`else
                if (last_step) begin
                    state_next = DONE;
                end
`endif
            end
            DONE: begin
                if (!bus.start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg    <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            quot_reg     <= '0;
            rem_reg      <= '0;
`ifdef DIVIDER_DBZ_EN
            dbz_reg      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        dividend_reg <= bus.in1;
                        divisor_reg  <= bus.in2;
                        count_reg    <= '0;
`ifdef DIVIDER_DBZ_EN
                        dbz_reg      <= (bus.in2 == '0);
`endif
                    end
                end
                BUSY: begin
`ifdef DIVIDER_DBZ_EN
                    if (dbz_reg) begin
                        quot_reg <= '1;
                        rem_reg  <= {1'b0, dividend_reg};
                    end else
`endif
                    begin
                        rem_reg      <= step_rem_out;
                        quot_reg     <= {quot_reg[N-2:0], step_q_bit};
                        dividend_reg <= {dividend_reg[N-2:0], 1'b0};
                        count_reg    <= last_step ? '0 : count_reg + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready     = (state_reg == DONE);
    assign bus.quotient  = quot_reg;
    assign bus.remainder = rem_reg[N-1:0];
`ifdef DIVIDER_DBZ_EN
    assign bus.div_by_zero = dbz_reg;
`endif

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: N=8 and N=128 instances on one clock.
// Expected results are queued at stimulus time and popped when ready rises.
module tb_divider;
    import divider_pkg::*;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    divider_if #(.N(8))   bus8 ();
    divider_if #(.N(128)) bus128 ();

    divider #(.N(8))   dut8   (.clock(clock), .reset(reset), .bus(bus8));
    divider #(.N(128)) dut128 (.clock(clock), .reset(reset), .bus(bus128));

    typedef struct {
        logic [127:0] q;
        logic [127:0] r;
        int           lat;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One N=8 transaction; hold>0 keeps start high through BUSY and DONE.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit toggle, input int hold);
        exp_t       e;
        int         edges;
        logic [7:0] q_now;
        @(negedge clock);
        bus8.in1   = a;
        bus8.in2   = b;
        bus8.start = 1'b1;
        e.q = (b == 8'd0) ? 128'hFF : 128'(a / b);
        e.r = (b == 8'd0) ? 128'(a) : 128'(a % b);
`ifdef DIVIDER_DBZ_EN
        e.lat = (b == 8'd0) ? 1 : 8;
        e.dbz = (b == 8'd0);
`else
        e.lat = 8;
        e.dbz = 1'b0;
`endif
        sb.push_back(e);
        @(negedge clock);
        if (hold == 0) bus8.start = 1'b0;
        edges = 0;
        while (!bus8.ready && edges < 40) begin
            if (toggle) begin
                bus8.in1 = 8'($urandom);
                bus8.in2 = 8'($urandom);
            end
            @(negedge clock);
            edges++;
        end
        e = sb.pop_front();
        check("latency", 128'(edges), 128'(e.lat));
        check("quotient", 128'(bus8.quotient), e.q);
        check("remainder", 128'(bus8.remainder), e.r);
`ifdef DIVIDER_DBZ_EN
        check("div_by_zero", 128'(bus8.div_by_zero), 128'(e.dbz));
`endif
        $display("op8 a=%0d b=%0d q=%0d r=%0d lat=%0d dbz=%0d",
                 a, b, bus8.quotient, bus8.remainder, edges, e.dbz);
        q_now = bus8.quotient;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_ready", 128'(bus8.ready), 128'd1);
            check("hold_quotient", 128'(bus8.quotient), 128'(q_now));
        end
        bus8.start = 1'b0;
        @(negedge clock);
        check("ready_drop", 128'(bus8.ready), 128'd0);
        check("idle_quotient", 128'(bus8.quotient), e.q);
        check("idle_remainder", 128'(bus8.remainder), e.r);
    endtask

    initial begin
        exp_t e;
        int   edges;
        bit   seen;

        reset        = 1'b1;
        bus8.start   = 1'b0;
        bus8.in1     = '0;
        bus8.in2     = '0;
        bus128.start = 1'b0;
        bus128.in1   = '0;
        bus128.in2   = '0;
        repeat (2) @(negedge clock);
        check("rst_ready", 128'(bus8.ready), 128'd0);
        check("rst_quotient", 128'(bus8.quotient), 128'd0);
        check("rst_remainder", 128'(bus8.remainder), 128'd0);
        check("rst_ready128", 128'(bus128.ready), 128'd0);
`ifdef DIVIDER_DBZ_EN
        check("rst_dbz", 128'(bus8.div_by_zero), 128'd0);
`endif
        reset = 1'b0;

        op8(8'd200, 8'd7, 1'b0, 0);
        op8(8'd13,  8'd0, 1'b0, 0);
        op8(8'd55,  8'd6, 1'b0, 5);
        op8(8'd9,   8'd9, 1'b0, 0);
        op8(8'd173, 8'd11, 1'b1, 0);
        op8(8'd255, 8'd255, 1'b1, 0);
        op8(8'd3,   8'd200, 1'b0, 0);

        // Abort mid-BUSY; start is also high on the reset edge to test priority.
        @(negedge clock);
        bus8.in1   = 8'd255;
        bus8.in2   = 8'd1;
        bus8.start = 1'b1;
        @(negedge clock);
        bus8.start = 1'b0;
        repeat (3) @(negedge clock);
        check("busy_partial_q", 128'(bus8.quotient), 128'd7);
        reset      = 1'b1;
        bus8.start = 1'b1;
        @(negedge clock);
        reset      = 1'b0;
        bus8.start = 1'b0;
        check("abort_ready", 128'(bus8.ready), 128'd0);
        check("abort_quotient", 128'(bus8.quotient), 128'd0);
        check("abort_remainder", 128'(bus8.remainder), 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus8.ready) seen = 1'b1;
        end
        check("abort_no_ready", 128'(seen), 128'd0);
        $display("abort test ready_seen=%0d", seen);

        for (int k = 0; k < 6; k++) begin
            op8(8'($urandom), 8'($urandom_range(0, 15)), k[0], 0);
        end

        // Wide instance: (2^127+5) / 2^64.
        @(negedge clock);
        bus128.in1   = (128'd1 << 127) + 128'd5;
        bus128.in2   = 128'd1 << 64;
        bus128.start = 1'b1;
        e.q   = 128'd1 << 63;
        e.r   = 128'd5;
        e.lat = 128;
        e.dbz = 1'b0;
        sb.push_back(e);
        @(negedge clock);
        bus128.start = 1'b0;
        edges = 0;
        while (!bus128.ready && edges < 200) begin
            @(negedge clock);
            edges++;
        end
        e = sb.pop_front();
        check("latency128", 128'(edges), 128'(e.lat));
        check("quotient128", bus128.quotient, e.q);
        check("remainder128", bus128.remainder, e.r);
        $display("op128 q=%0h r=%0h lat=%0d", bus128.quotient, bus128.remainder, edges);
        @(negedge clock);
        check("ready_drop128", 128'(bus128.ready), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
